display_conversion_scheduler: RTL and testbench

- Sequences display of the 12-bit neural output on the 4-digit seven-segment panel.
- Accepts a new value through a valid/ready handshake. Converts it to four BCD digits with a 12-cycle iterative shift-add-3 (double dabble) engine.
- Double-buffers the digits and time-multiplexes them onto the shared seg/an pins with a programmable refresh divider and optional leading-zero blanking.
- Sits between the classifier output register and the board display pins. Replaces the combinational converter + controller pair.

---
 rtl/display_conversion_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_display_conversion_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_conversion_scheduler.sv
// -----------------------------------------------------------------------------
// display_conversion_scheduler
//
// Takes a 12-bit unsigned value through a valid/ready handshake. It converts the
// value to four BCD digits with a 12-cycle shift-add-3 (double dabble) engine
// and commits the digits to a display buffer. The buffer is time-multiplexed
// onto a 4-digit, active-low seven-segment panel. Leading-zero blanking is
// optional.
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   value_valid  requester has a value on `value`
//   value[11:0]  unsigned binary value to display (0..4095)
//   value_ready  block can accept a value (high only in IDLE)
//   blank_lz     1 = blank leading zero digits, sampled every cycle
//   conv_done    one-cycle pulse: new digits committed to the display buffer
//   seg[6:0]     segment cathodes, active-low, seg[0]=a .. seg[6]=g
//   an[3:0]      digit anodes, active-low one-hot, an[0]=ones digit
// -----------------------------------------------------------------------------
module display_conversion_scheduler #(
  parameter int REFRESH_DIV = 100000,  // cycles each digit is driven (>= 2)
  parameter int CNT_W       = 17       // 2**CNT_W >= REFRESH_DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        value_valid,
  input  logic [11:0] value,
  output logic        value_ready,
  input  logic        blank_lz,
  output logic        conv_done,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t             state;
  logic [11:0]        bin_q;      // binary shift register
  logic [15:0]        bcd_q;      // BCD accumulator
  logic [3:0]         iter_q;     // conversion iteration 0..11
  logic [15:0]        disp_q;     // committed digits {d3,d2,d1,d0}
  logic [CNT_W-1:0]   refresh_q;
  logic [1:0]         idx_q;      // digit currently being scanned

  // Seven-segment pattern, g..a active-low; any non-decimal code shows blank.
  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 7'b1000000;
      4'd1:    encode = 7'b1111001;
      4'd2:    encode = 7'b0100100;
      4'd3:    encode = 7'b0110000;
      4'd4:    encode = 7'b0011001;
      4'd5:    encode = 7'b0010010;
      4'd6:    encode = 7'b0000010;
      4'd7:    encode = 7'b1111000;
      4'd8:    encode = 7'b0000000;
      4'd9:    encode = 7'b0010000;
      default: encode = 7'b1111111;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // One double-dabble step: add 3 to each nibble >= 5, then shift {bcd,bin}.
  // ---------------------------------------------------------------------------
  logic [15:0] bcd_adj;
  logic [27:0] shifted;
  logic [15:0] bcd_next;
  logic [11:0] bin_next;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shifted  = {bcd_adj, bin_q} << 1;
    bcd_next = shifted[27:12];
    bin_next = shifted[11:0];
  end

  // ---------------------------------------------------------------------------
  // Handshake / conversion FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      value_ready <= 1'b1;
      conv_done   <= 1'b0;
      bin_q       <= '0;
      bcd_q       <= '0;
      iter_q      <= '0;
      // NOTE: the display buffer is a few flops rather than a memory, and it is
      // reset so that an aborted conversion leaves the panel showing 0.
      disp_q      <= '0;
    end else begin
      conv_done <= 1'b0;
      case (state)
        IDLE: begin
          if (value_valid && value_ready) begin
            bin_q       <= value;
            bcd_q       <= '0;
            iter_q      <= '0;
            value_ready <= 1'b0;
            state       <= CONVERT;
          end
        end
        CONVERT: begin
          bin_q <= bin_next;
          bcd_q <= bcd_next;
          if (iter_q == 4'd11) begin
            disp_q      <= bcd_next;
            conv_done   <= 1'b1;
            value_ready <= 1'b1;
            state       <= IDLE;
          end else begin
            iter_q <= iter_q + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Free-running refresh divider and scan index (independent of the FSM)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_q <= '0;
      idx_q     <= '0;
    end else if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_q <= '0;
      idx_q     <= idx_q + 2'd1;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit select, leading-zero blanking and registered pin drive
  // ---------------------------------------------------------------------------
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] digit;
  logic       blank;
  logic [6:0] seg_next;

  assign {d3, d2, d1, d0} = disp_q;

  always_comb begin
    digit = d0;
    blank = 1'b0;
    case (idx_q)
      2'd0: digit = d0;
      2'd1: begin
        digit = d1;
        blank = (d3 == 4'd0) && (d2 == 4'd0) && (d1 == 4'd0);
      end
      2'd2: begin
        digit = d2;
        blank = (d3 == 4'd0) && (d2 == 4'd0);
      end
      2'd3: begin
        digit = d3;
        blank = (d3 == 4'd0);
      end
      default: ;
    endcase
    // The anode stays active for a blanked digit; only the cathodes go dark.
    seg_next = (blank_lz && blank) ? 7'b1111111 : encode(digit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 7'b1111111;
      an  <= 4'b1111;
    end else begin
      seg <= seg_next;
      an  <= ~(4'b0001 << idx_q);
    end
  end

endmodule

// File: tb/tb_display_conversion_scheduler.sv
// -----------------------------------------------------------------------------
// Bench for display_conversion_scheduler with REFRESH_DIV=4. Expected values
// come from decimal arithmetic and a segment table. Accepted values are queued
// at accept time and popped when conv_done pulses. After a pop, the scanned
// seg/an pins are compared against the popped value.
// -----------------------------------------------------------------------------
module tb_display_conversion_scheduler;

  localparam int REFRESH_DIV = 4;
  localparam int CNT_W       = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        value_valid;
  logic [11:0] value;
  logic        value_ready;
  logic        blank_lz;
  logic        conv_done;
  logic [6:0]  seg;
  logic [3:0]  an;

  int vectors     = 0;
  int miscompares = 0;

  logic [11:0] sb_q[$];     // accepted values awaiting commit
  logic [11:0] shown;       // value the panel should be displaying

  display_conversion_scheduler #(
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value_valid (value_valid),
    .value       (value),
    .value_ready (value_ready),
    .blank_lz    (blank_lz),
    .conv_done   (conv_done),
    .seg         (seg),
    .an          (an)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected cathode pattern for digit position idx of value v.
  function automatic logic [6:0] exp_seg(input int v, input int idx, input logic blz);
    logic [6:0] table_q [10];
    int d [4];
    logic blank;
    table_q = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    d[0] = v % 10;
    d[1] = (v / 10) % 10;
    d[2] = (v / 100) % 10;
    d[3] = v / 1000;
    case (idx)
      3:       blank = (d[3] == 0);
      2:       blank = (d[3] == 0) && (d[2] == 0);
      1:       blank = (d[3] == 0) && (d[2] == 0) && (d[1] == 0);
      default: blank = 1'b0;
    endcase
    return (blz && blank) ? 7'b1111111 : table_q[d[idx]];
  endfunction

  // Check the digit now on the pins against value v; returns the active index.
  task automatic check_seg_now(input int v, output int idx);
    idx = -1;
    case (an)
      4'b1110: idx = 0;
      4'b1101: idx = 1;
      4'b1011: idx = 2;
      4'b0111: idx = 3;
      default: idx = -1;
    endcase
    chk("an_onehot", 16'(idx >= 0), 16'd1);
    if (idx >= 0)
      chk($sformatf("seg_v%0d_d%0d", v, idx), 16'(seg), 16'(exp_seg(v, idx, blank_lz)));
  endtask

  // Watch one full scan (16 cycles) and check every digit shown.
  task automatic check_disp(input int v);
    logic [3:0] seen;
    int idx;
    seen = '0;
    for (int k = 0; k < 4 * REFRESH_DIV; k++) begin
      tick();
      check_seg_now(v, idx);
      if (idx >= 0) seen[idx] = 1'b1;
    end
    chk($sformatf("scan_cover_v%0d", v), 16'(seen), 16'hF);
  endtask

  // Present v and accept it on the next edge; optionally keep value_valid high.
  task automatic start(input logic [11:0] v, input logic hold);
    chk("ready_before_accept", 16'(value_ready), 16'd1);
    value       = v;
    value_valid = 1'b1;
    sb_q.push_back(v);
    tick();
    chk("ready_after_accept", 16'(value_ready), 16'd0);
    if (!hold) value_valid = 1'b0;
  endtask

  // Wait for the commit. The old value must stay on the panel throughout.
  // Checks busy length and the conv_done pulse, then pops the scoreboard.
  task automatic finish_conv();
    int cycles;
    int idx;
    cycles = 0;
    while (!value_ready && cycles < 40) begin
      chk("seg_during_convert", 16'(conv_done), 16'd0);
      check_seg_now(shown, idx);
      cycles++;
      tick();
    end
    chk("busy_cycles", 16'(cycles), 16'd12);
    chk("conv_done_pulse", 16'(conv_done), 16'd1);
    chk("scoreboard_nonempty", 16'(sb_q.size() > 0), 16'd1);
    if (sb_q.size() > 0) shown = sb_q.pop_front();
  endtask

  initial begin
    int idx;
    rst_n       = 1'b0;
    value_valid = 1'b0;
    value       = '0;
    blank_lz    = 1'b0;
    shown       = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_ready", 16'(value_ready), 16'd1);
    chk("rst_conv_done", 16'(conv_done), 16'd0);

    // Release: each anode is held for exactly REFRESH_DIV cycles, showing 0000.
    rst_n = 1'b1;
    for (int k = 0; k < 4 * REFRESH_DIV; k++) begin
      logic [3:0] exp_an;
      tick();
      exp_an = ~(4'b0001 << (k / REFRESH_DIV));
      chk($sformatf("scan_an_%0d", k), 16'(an), 16'(exp_an));
      chk($sformatf("scan_seg_%0d", k), 16'(seg), 16'h40);
    end

    // Full-scale value
    start(12'd4095, 1'b0);
    finish_conv();
    tick();
    chk("conv_done_single", 16'(conv_done), 16'd0);
    check_disp(4095);

    // Small value, blanked then unblanked
    blank_lz = 1'b1;
    start(12'd7, 1'b0);
    finish_conv();
    tick();
    chk("conv_done_single", 16'(conv_done), 16'd0);
    check_disp(7);
    blank_lz = 1'b0;
    check_disp(7);

    // Embedded zeros are not leading zeros
    blank_lz = 1'b1;
    start(12'd1005, 1'b0);
    finish_conv();
    tick();
    check_disp(1005);

    // Held request while busy: 123 is taken only on the first IDLE cycle
    start(12'd4095, 1'b1);
    value = 12'd123;
    finish_conv();
    sb_q.push_back(12'd123);
    tick();
    chk("held_accept_first_idle", 16'(value_ready), 16'd0);
    chk("conv_done_single", 16'(conv_done), 16'd0);
    value_valid = 1'b0;
    value       = 12'd999;
    finish_conv();
    tick();
    check_disp(123);

    // Reset during iteration 6 aborts the conversion
    start(12'd555, 1'b0);
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_seg", 16'(seg), 16'h7F);
    chk("abort_an", 16'(an), 16'hF);
    chk("abort_ready", 16'(value_ready), 16'd1);
    void'(sb_q.pop_back());
    shown = '0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    blank_lz = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("abort_no_conv_done", 16'(conv_done), 16'd0);
      chk("abort_ready_idle", 16'(value_ready), 16'd1);
      check_seg_now(0, idx);
    end
    check_disp(0);

    // Zero converts to 0000; blanking leaves only the ones digit lit
    start(12'd0, 1'b0);
    finish_conv();
    tick();
    check_disp(0);
    blank_lz = 1'b1;
    check_disp(0);

    chk("scoreboard_drained", 16'(sb_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
